// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: converts EX/MEM load/store requests into a
// req/ack transaction, stalls the pipeline while outstanding, flags misalign/timeout.
module mem_access_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [DATA_W-1:0] ALUresult_i,
  input  logic [DATA_W-1:0] WriteData_i,
  output logic [DATA_W-1:0] MemData_o,
  output logic              stall_o,
  output logic              misalign_o,
  output logic              bus_err_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [DATA_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  input  logic              dmem_ack_i
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              req_q, req_d;
  logic              misalign_q, misalign_d;
  logic              bus_err_q, bus_err_d;
  logic              stall;
  logic              acc;
  logic              misaligned;
  logic              timeout_hit;

  assign acc         = MemRead_i | MemWrite_i;
  assign misaligned  = (ALUresult_i[1:0] != 2'b00);
  assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_data_d = mem_data_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    req_d      = 1'b0;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;
    stall      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (acc) begin
          stall = 1'b1;
          if (misaligned) begin
            misalign_d = 1'b1;
            state_d    = StDone;
          end else begin
            addr_d  = {ALUresult_i[DATA_W-1:2], 2'b00};
            wdata_d = WriteData_i;
            we_d    = MemWrite_i;
            req_d   = 1'b1;
            cnt_d   = 8'd0;
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        stall = 1'b1;
        // Ack takes priority over a simultaneous timeout.
        if (dmem_ack_i) begin
          if (!we_q) mem_data_d = dmem_rdata_i;
          state_d = StDone;
        end else if (timeout_hit) begin
          mem_data_d = '0;
          bus_err_d  = 1'b1;
          state_d    = StDone;
        end else begin
          req_d = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      mem_data_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      req_q      <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_data_q <= mem_data_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      req_q      <= req_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Gated by reset so a held request cannot raise stall while in reset.
  assign stall_o      = rst_i & stall;
  assign MemData_o    = mem_data_q;
  assign misalign_o   = misalign_q;
  assign bus_err_o    = bus_err_q;
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: transaction-level timeline model with
// per-cycle comparison, directed scenarios and randomized traffic.
module tb_mem_access_unit;

  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          MemRead_i = 1'b0, MemWrite_i = 1'b0, dmem_ack_i = 1'b0;
  logic [DW-1:0] ALUresult_i = '0, WriteData_i = '0, dmem_rdata_i = '0;
  logic [DW-1:0] MemData_o, dmem_addr_o, dmem_wdata_o;
  logic          stall_o, misalign_o, bus_err_o, dmem_req_o, dmem_we_o;

  mem_access_unit #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .ALUresult_i (ALUresult_i),
    .WriteData_i (WriteData_i),
    .MemData_o   (MemData_o),
    .stall_o     (stall_o),
    .misalign_o  (misalign_o),
    .bus_err_o   (bus_err_o),
    .dmem_req_o  (dmem_req_o),
    .dmem_we_o   (dmem_we_o),
    .dmem_addr_o (dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o),
    .dmem_rdata_i(dmem_rdata_i),
    .dmem_ack_i  (dmem_ack_i)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_stall = 0;
  int n_req = 0;
  bit check_en = 1'b0;

  // Model: expected per-cycle controls plus architectural state of the unit.
  logic          e_stall, e_req, e_mis, e_berr;
  logic          m_we;
  logic [DW-1:0] m_data, m_addr, m_wdata;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk1("stall_o", stall_o, e_stall);
      chk1("dmem_req_o", dmem_req_o, e_req);
      chk1("misalign_o", misalign_o, e_mis);
      chk1("bus_err_o", bus_err_o, e_berr);
      chk1("dmem_we_o", dmem_we_o, m_we);
      chk32("MemData_o", MemData_o, m_data);
      chk32("dmem_addr_o", dmem_addr_o, m_addr);
      chk32("dmem_wdata_o", dmem_wdata_o, m_wdata);
      if (stall_o) n_stall++;
      if (dmem_req_o) n_req++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    dmem_rdata_i = $urandom;
  endtask

  task automatic set_idle();
    MemRead_i   = 1'b0;
    MemWrite_i  = 1'b0;
    ALUresult_i = $urandom;
    WriteData_i = $urandom;
    dmem_ack_i  = 1'($urandom_range(0, 1));
    e_stall = 1'b0; e_req = 1'b0; e_mis = 1'b0; e_berr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_idle();
      step();
    end
  endtask

  task automatic model_reset();
    m_data = '0; m_addr = '0; m_wdata = '0; m_we = 1'b0;
  endtask

  // One access. ack_at in 1..TO acks in that BUSY cycle; anything else times out.
  task automatic txn(input logic rd, input logic wr, input logic [DW-1:0] addr,
                     input logic [DW-1:0] wdata, input int ack_at,
                     input bit fix_rdata, input logic [DW-1:0] rdv);
    logic          mis;
    bit            timed;
    int            nb;
    logic [DW-1:0] rd_val;
    mis    = (addr[1:0] != 2'b00);
    timed  = !(ack_at >= 1 && ack_at <= TO);
    nb     = timed ? TO : ack_at;
    rd_val = '0;
    MemRead_i = rd; MemWrite_i = wr; ALUresult_i = addr; WriteData_i = wdata;
    dmem_ack_i = 1'($urandom_range(0, 1));
    e_stall = 1'b1; e_req = 1'b0; e_mis = 1'b0; e_berr = 1'b0;
    if (!mis) begin
      for (int c = 1; c <= nb; c++) begin
        step();
        if (c == 1) begin
          m_addr = {addr[DW-1:2], 2'b00}; m_wdata = wdata; m_we = wr;
        end
        e_req = 1'b1; e_stall = 1'b1;
        dmem_ack_i = (c == nb) && !timed;
        if (dmem_ack_i) begin
          if (fix_rdata) dmem_rdata_i = rdv;
          rd_val = dmem_rdata_i;
        end
      end
    end
    step();
    e_stall = 1'b0; e_req = 1'b0; e_mis = mis; e_berr = !mis && timed;
    dmem_ack_i = 1'($urandom_range(0, 1));
    if (!mis) begin
      if (timed) m_data = '0;
      else if (!wr) m_data = rd_val;
    end
    step();
    set_idle();
  endtask

  int s0, r0;

  initial begin
    set_idle();
    model_reset();
    rst_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk32("reset MemData_o", MemData_o, 32'h0);
    chk1("reset stall_o", stall_o, 1'b0);
    chk1("reset misalign_o", misalign_o, 1'b0);
    chk1("reset bus_err_o", bus_err_o, 1'b0);
    chk1("reset dmem_req_o", dmem_req_o, 1'b0);
    chk1("reset dmem_we_o", dmem_we_o, 1'b0);
    chk32("reset dmem_addr_o", dmem_addr_o, 32'h0);
    chk32("reset dmem_wdata_o", dmem_wdata_o, 32'h0);
    MemRead_i = 1'b1;
    #1;
    chk1("reset stall_o with request", stall_o, 1'b0);
    rst_i = 1'b1;
    set_idle();
    check_en = 1'b1;
    idle(2);

    // Load, ack in first BUSY cycle
    s0 = n_stall;
    txn(1'b1, 1'b0, 32'h10, 32'h0, 1, 1'b1, 32'hCAFEBABE);
    chk32("t1 stall cycles", 32'(n_stall - s0), 32'd2);
    chk32("t1 MemData_o", MemData_o, 32'hCAFEBABE);
    idle(1);

    // Store, ack after 4 BUSY cycles
    r0 = n_req;
    txn(1'b0, 1'b1, 32'h20, 32'h12345678, 4, 1'b0, '0);
    chk32("t2 req cycles", 32'(n_req - r0), 32'd4);
    chk32("t2 MemData_o kept", MemData_o, 32'hCAFEBABE);
    chk32("t2 wdata", dmem_wdata_o, 32'h12345678);
    idle(1);

    // Misaligned load
    s0 = n_stall; r0 = n_req;
    txn(1'b1, 1'b0, 32'h13, 32'h0, 1, 1'b0, '0);
    chk32("t3 stall cycles", 32'(n_stall - s0), 32'd1);
    chk32("t3 req cycles", 32'(n_req - r0), 32'd0);
    idle(1);

    // Timeout
    r0 = n_req;
    txn(1'b1, 1'b0, 32'h40, 32'h0, 0, 1'b0, '0);
    chk32("t4 req cycles", 32'(n_req - r0), 32'd16);
    chk32("t4 MemData_o cleared", MemData_o, 32'h0);
    idle(1);

    // Ack in last possible BUSY cycle
    txn(1'b1, 1'b0, 32'h44, 32'h0, TO, 1'b1, 32'h0BADF00D);
    chk32("t5 MemData_o", MemData_o, 32'h0BADF00D);
    idle(1);

    // Both read and write asserted: store wins
    txn(1'b1, 1'b1, 32'h48, 32'hA5A5A5A5, 2, 1'b0, '0);
    chk1("t7 dmem_we_o", dmem_we_o, 1'b1);
    chk32("t7 MemData_o kept", MemData_o, 32'h0BADF00D);
    idle(1);

    // Reset in the middle of BUSY
    MemRead_i = 1'b1; MemWrite_i = 1'b0; ALUresult_i = 32'h80; dmem_ack_i = 1'b0;
    e_stall = 1'b1; e_req = 1'b0;
    step();
    m_addr = 32'h80; m_wdata = WriteData_i; m_we = 1'b0;
    e_req = 1'b1; dmem_ack_i = 1'b0;
    step();
    step();
    #2;
    check_en = 1'b0;
    rst_i = 1'b0;
    #1;
    chk1("t6 dmem_req_o", dmem_req_o, 1'b0);
    chk1("t6 stall_o", stall_o, 1'b0);
    chk32("t6 MemData_o", MemData_o, 32'h0);
    model_reset();
    step();
    rst_i = 1'b1;
    set_idle();
    check_en = 1'b1;
    idle(2);
    txn(1'b1, 1'b0, 32'h84, 32'h0, 3, 1'b1, 32'h600DCAFE);
    chk32("t6 load after reset", MemData_o, 32'h600DCAFE);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      int            k, a, ack_at;
      logic          rd, wr;
      logic [DW-1:0] addr;
      k  = int'($urandom_range(0, 2));
      rd = (k != 1);
      wr = (k != 0);
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      a = int'($urandom_range(0, 9));
      if (a < 6) ack_at = int'($urandom_range(1, 6));
      else if (a < 8) ack_at = int'($urandom_range(7, TO));
      else ack_at = 0;
      txn(rd, wr, addr, $urandom, ack_at, 1'b0, '0);
      idle(int'($urandom_range(0, 2)));
    end

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
